// File: rtl/vx_wb_pkg.sv
// Shared types for the GPR writeback arbiter: the packet struct, the scoreboard release record and the lock FSM states.
// The struct widths are the package constants; the arbiter's width parameters default to them and must stay equal to them.
package vx_wb_pkg;

  localparam int VX_WB_NUM_THREADS = 4;
  localparam int VX_WB_XLEN        = 32;
  localparam int VX_WB_NR_BITS     = 6;
  localparam int VX_WB_WIS_W       = 2;

  typedef struct packed {
    logic [VX_WB_WIS_W-1:0]                  wis;
    logic [VX_WB_NUM_THREADS-1:0]            tmask;
    logic [VX_WB_NR_BITS-1:0]                rd;
    logic                                    wb;
    logic                                    sop;
    logic                                    eop;
    logic [VX_WB_NUM_THREADS*VX_WB_XLEN-1:0] data;
  } wb_packet_t;

  typedef struct packed {
    logic [VX_WB_WIS_W-1:0]   wis;
    logic [VX_WB_NR_BITS-1:0] rd;
  } release_t;

  typedef enum logic [0:0] {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_wb_lock_rr_arbiter.sv
// Round-robin arbiter with sop..eop grant locking: a requester that opens a multi-packet
// transfer keeps exclusive grant until its eop is accepted; the pointer moves only on eop.
module vx_wb_lock_rr_arbiter
  import vx_wb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             grant_sop,
  input  logic             grant_eop,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  lock_state_e      state_r;
  lock_state_e      state_next_s;
  logic             held_s;
  logic [IDX_W-1:0] lock_idx_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] rr_next_s;
  logic [31:0]      cand_s;

  // Lock state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LOCK_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Lock next-state: open on sop-without-eop, close on the locked unit's eop
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LOCK_IDLE: begin
        if (grant_valid && grant_sop && !grant_eop) begin
          state_next_s = LOCK_HELD;
        end else begin
          state_next_s = LOCK_IDLE;
        end
      end
      LOCK_HELD: begin
        if (grant_valid && grant_eop) begin
          state_next_s = LOCK_IDLE;
        end else begin
          state_next_s = LOCK_HELD;
        end
      end
      default: state_next_s = LOCK_IDLE;
    endcase
  end

  // Lock state decode
  always_comb begin
    held_s = 1'b0;
    case (state_r)
      LOCK_IDLE: held_s = 1'b0;
      LOCK_HELD: held_s = 1'b1;
      default:   held_s = 1'b0;
    endcase
  end

  assign rr_next_s = (grant_idx == IDX_W'(N - 1)) ? {IDX_W{1'b0}} : grant_idx + IDX_W'(1);

  // Locked unit index and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_idx_r <= {IDX_W{1'b0}};
      rr_ptr_r   <= {IDX_W{1'b0}};
    end else begin
      if (!held_s && grant_valid && grant_sop && !grant_eop) begin
        lock_idx_r <= grant_idx;
      end
      if (grant_valid && grant_eop) begin
        rr_ptr_r <= rr_next_s;
      end
    end
  end

  // Grant: locked unit only while held, otherwise first requester at or after rr_ptr
  always_comb begin
    grant       = {N{1'b0}};
    grant_idx   = {IDX_W{1'b0}};
    grant_valid = 1'b0;
    cand_s      = 32'd0;
    if (held_s) begin
      if (req[lock_idx_r]) begin
        grant[lock_idx_r] = 1'b1;
        grant_idx         = lock_idx_r;
        grant_valid       = 1'b1;
      end else begin
        grant_valid = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cand_s = (32'(rr_ptr_r) + 32'(k)) % 32'(N);
        if (req[IDX_W'(cand_s)] && !grant_valid) begin
          grant[IDX_W'(cand_s)] = 1'b1;
          grant_idx             = IDX_W'(cand_s);
          grant_valid           = 1'b1;
        end else begin
          grant_valid = grant_valid;
        end
      end
    end
  end

endmodule

// File: rtl/vx_wb_arbiter.sv
// Merges execute-unit result streams into the single GPR writeback port and raises the scoreboard
// release on the last packet of a writing instruction. Define VX_WB_ARB_PERF_EN for the perf_stalls counter.
module vx_wb_arbiter
  import vx_wb_pkg::*;
#(
  parameter int NUM_UNITS     = 4,
  parameter int NUM_THREADS   = VX_WB_NUM_THREADS,
  parameter int XLEN          = VX_WB_XLEN,
  parameter int NR_BITS       = VX_WB_NR_BITS,
  parameter int WIS_W         = VX_WB_WIS_W,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_UNITS-1:0]              in_valid,
  output logic [NUM_UNITS-1:0]              in_ready,
  input  logic [NUM_UNITS*WIS_W-1:0]        in_wis,
  input  logic [NUM_UNITS*NUM_THREADS-1:0]  in_tmask,
  input  logic [NUM_UNITS*NR_BITS-1:0]      in_rd,
  input  logic [NUM_UNITS-1:0]              in_wb,
  input  logic [NUM_UNITS-1:0]              in_sop,
  input  logic [NUM_UNITS-1:0]              in_eop,
  input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] in_data,
  output logic                              wb_valid,
  output logic [WIS_W-1:0]                  wb_wis,
  output logic [NUM_THREADS-1:0]            wb_tmask,
  output logic [NR_BITS-1:0]                wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]       wb_data,
  output logic                              wb_sop,
  output logic                              wb_eop,
  output logic                              rel_valid,
  output logic [WIS_W-1:0]                  rel_wis,
  output logic [NR_BITS-1:0]                rel_rd
`ifdef VX_WB_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]          perf_stalls
`endif
);

  localparam int IDX_W = idx_width(NUM_UNITS);
  localparam int PKT_W = $bits(wb_packet_t);

  wb_packet_t           pkt_s [NUM_UNITS];
  wb_packet_t           sel_s;
  wb_packet_t           out_r;
  release_t             rel_r;
  logic [NUM_UNITS-1:0] grant_s;
  logic [IDX_W-1:0]     grant_idx_s;
  logic                 fire_s;
  logic                 wr_en_s;
  logic                 wb_valid_r;
  logic                 rel_valid_r;

  // Unpack the flat per-unit buses into packets
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      pkt_s[i].wis   = in_wis[i*WIS_W +: WIS_W];
      pkt_s[i].tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
      pkt_s[i].rd    = in_rd[i*NR_BITS +: NR_BITS];
      pkt_s[i].wb    = in_wb[i];
      pkt_s[i].sop   = in_sop[i];
      pkt_s[i].eop   = in_eop[i];
      pkt_s[i].data  = in_data[i*NUM_THREADS*XLEN +: NUM_THREADS*XLEN];
    end
  end

  // One-hot AND-OR select of the granted packet
  always_comb begin
    sel_s = wb_packet_t'({PKT_W{1'b0}});
    for (int i = 0; i < NUM_UNITS; i++) begin
      sel_s = wb_packet_t'(sel_s | (pkt_s[i] & {PKT_W{grant_s[i]}}));
    end
  end

  vx_wb_lock_rr_arbiter #(
    .N (NUM_UNITS)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (in_valid),
    .grant_sop   (sel_s.sop),
    .grant_eop   (sel_s.eop),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (fire_s)
  );

  assign in_ready = grant_s;
  // Writes to r0 and non-writing packets are consumed silently
  assign wr_en_s  = fire_s & sel_s.wb & (|sel_s.rd);

  // Write and release strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_r  <= 1'b0;
      rel_valid_r <= 1'b0;
    end else begin
      wb_valid_r  <= wr_en_s;
      rel_valid_r <= wr_en_s & sel_s.eop;
    end
  end

  // Payload registers load on every accepted packet and are left unreset
  always_ff @(posedge clk) begin
    if (fire_s) begin
      out_r     <= sel_s;
      rel_r.wis <= sel_s.wis;
      rel_r.rd  <= sel_s.rd;
    end
  end

  assign wb_valid  = wb_valid_r;
  assign wb_wis    = out_r.wis;
  assign wb_tmask  = out_r.tmask;
  assign wb_rd     = out_r.rd;
  assign wb_data   = out_r.data;
  assign wb_sop    = out_r.sop;
  assign wb_eop    = out_r.eop;
  assign rel_valid = rel_valid_r;
  assign rel_wis   = rel_r.wis;
  assign rel_rd    = rel_r.rd;

`ifdef VX_WB_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_stalls_r;

  // Count cycles in which some requester is held off
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_r <= {PERF_CTR_BITS{1'b0}};
    end else if (|(in_valid & ~grant_s)) begin
      perf_stalls_r <= perf_stalls_r + PERF_CTR_BITS'(1);
    end else begin
      perf_stalls_r <= perf_stalls_r;
    end
  end

  assign perf_stalls = perf_stalls_r;
`endif

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Scoreboard bench for vx_wb_arbiter: directed per-cycle vectors push expected writes tagged
// with their cycle, a negedge monitor pops and compares. Define VX_WB_ARB_PERF_EN for the counter checks.
module tb_vx_wb_arbiter;
  import vx_wb_pkg::*;

  localparam int NU  = 4;
  localparam int NT  = 4;
  localparam int XL  = 32;
  localparam int NRB = 6;
  localparam int WW  = 2;
  localparam int PCB = 44;

  logic              clk = 1'b0;
  logic              reset;
  logic [NU-1:0]     in_valid, in_ready, in_wb, in_sop, in_eop;
  logic [NU*WW-1:0]  in_wis;
  logic [NU*NT-1:0]  in_tmask;
  logic [NU*NRB-1:0] in_rd;
  logic [NU*NT*XL-1:0] in_data;
  logic              wb_valid, wb_sop, wb_eop, rel_valid;
  logic [WW-1:0]     wb_wis, rel_wis;
  logic [NT-1:0]     wb_tmask;
  logic [NRB-1:0]    wb_rd, rel_rd;
  logic [NT*XL-1:0]  wb_data;
`ifdef VX_WB_ARB_PERF_EN
  logic [PCB-1:0]    perf_stalls;
`endif

  vx_wb_arbiter #(
    .NUM_UNITS(NU), .NUM_THREADS(NT), .XLEN(XL), .NR_BITS(NRB), .WIS_W(WW), .PERF_CTR_BITS(PCB)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wis(in_wis), .in_tmask(in_tmask),
    .in_rd(in_rd), .in_wb(in_wb), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_tmask(wb_tmask), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop),
    .rel_valid(rel_valid), .rel_wis(rel_wis), .rel_rd(rel_rd)
`ifdef VX_WB_ARB_PERF_EN
    , .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int             cyc;
    logic [WW-1:0]  wis;
    logic [NT-1:0]  tmask;
    logic [NRB-1:0] rd;
    logic [NT*XL-1:0] data;
    logic           sop;
    logic           eop;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  // Monitor: every write or release must match the oldest expected entry, in the expected cycle
  always @(negedge clk) begin
    if (wb_valid === 1'b1 || rel_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write cyc=%0d got wb_valid=%b rel_valid=%b rd=%0d", cyc, wb_valid, rel_valid, wb_rd);
      end else begin
        m = sb.pop_front();
        if (cyc != m.cyc || wb_valid !== 1'b1 || wb_rd !== m.rd || wb_wis !== m.wis ||
            wb_tmask !== m.tmask || wb_data !== m.data || wb_sop !== m.sop || wb_eop !== m.eop ||
            rel_valid !== m.eop || (m.eop && (rel_rd !== m.rd || rel_wis !== m.wis))) begin
          failures++;
          $display("FAIL write_match got cyc=%0d v=%b rd=%0d wis=%0d tm=%h sop=%b eop=%b rel=%b rel_rd=%0d data=%h want cyc=%0d rd=%0d wis=%0d tm=%h sop=%b eop=%b rel=%b data=%h",
                   cyc, wb_valid, wb_rd, wb_wis, wb_tmask, wb_sop, wb_eop, rel_valid, rel_rd, wb_data,
                   m.cyc, m.rd, m.wis, m.tmask, m.sop, m.eop, m.eop, m.data);
        end
      end
    end
  end

  task automatic clear_all();
    in_valid = '0; in_wb = '0; in_sop = '0; in_eop = '0;
    in_wis = '0; in_tmask = '0; in_rd = '0; in_data = '0;
  endtask

  task automatic set_unit(input int u, input logic [NT-1:0] tmask, input logic [NRB-1:0] rd,
                          input logic wb, input logic sop, input logic eop, input logic [XL-1:0] base);
    in_valid[u] = 1'b1;
    in_wis[u*WW +: WW] = WW'(u);
    in_tmask[u*NT +: NT] = tmask;
    in_rd[u*NRB +: NRB] = rd;
    in_wb[u] = wb;
    in_sop[u] = sop;
    in_eop[u] = eop;
    for (int l = 0; l < NT; l++) in_data[(u*NT+l)*XL +: XL] = base + XL'(l);
  endtask

  // Check the hand-computed grant, queue the write it implies, advance one cycle
  task automatic cycle(input logic [NU-1:0] exp_ready, input string tag);
    exp_t e;
    #1;
    checks++;
    if (in_ready !== exp_ready) begin
      failures++;
      $display("FAIL %s in_ready got %b want %b", tag, in_ready, exp_ready);
    end
    for (int u = 0; u < NU; u++) begin
      if (exp_ready[u] && in_wb[u] && in_rd[u*NRB +: NRB] != '0) begin
        e.cyc   = cyc + 1;
        e.wis   = WW'(u);
        e.tmask = in_tmask[u*NT +: NT];
        e.rd    = in_rd[u*NRB +: NRB];
        e.data  = in_data[u*NT*XL +: NT*XL];
        e.sop   = in_sop[u];
        e.eop   = in_eop[u];
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b0 || rel_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs got wb_valid=%b rel_valid=%b want 0 0", wb_valid, rel_valid);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [NT*XL-1:0] t1_data;
    reset = 1'b1;
    clear_all();
    repeat (3) @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || rel_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got wb_valid=%b rel_valid=%b want 0 0", wb_valid, rel_valid);
    end
    reset = 1'b0;
    cycle(4'b0000, "idle");

    // Single-packet write from unit 0
    set_unit(0, 4'b1111, 6'd5, 1'b1, 1'b1, 1'b1, 32'hA);
    cycle(4'b0001, "t1");
    t1_data = {32'hD, 32'hC, 32'hB, 32'hA};
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 6'd5 || rel_valid !== 1'b1 || rel_rd !== 6'd5 || wb_data !== t1_data) begin
      failures++;
      $display("FAIL t1_direct got v=%b rd=%0d rel=%b rel_rd=%0d data=%h want 1 5 1 5 %h",
               wb_valid, wb_rd, rel_valid, rel_rd, wb_data, t1_data);
    end
    clear_all();
    cycle(4'b0000, "t1_idle");

    // Round-robin over four single-packet requesters from reset
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int u = 0; u < NU; u++) set_unit(u, 4'(c + u + 1), 6'(8*c + u + 1), 1'b1, 1'b1, 1'b1, 32'(c*16 + u));
      cycle(4'(1 << (c % 4)), "rr_order");
    end
    clear_all();

    // Unit 1 three-packet instruction with a gap while unit 2 contends
    set_unit(1, 4'b0011, 6'd7, 1'b1, 1'b1, 1'b0, 32'h100);
    set_unit(2, 4'b1000, 6'd9, 1'b1, 1'b1, 1'b1, 32'h200);
    cycle(4'b0010, "lock_sop");
    set_unit(1, 4'b0101, 6'd7, 1'b1, 1'b0, 1'b0, 32'h110);
    cycle(4'b0010, "lock_mid");
    in_valid[1] = 1'b0;
    cycle(4'b0000, "lock_bubble");
    set_unit(1, 4'b1100, 6'd7, 1'b1, 1'b0, 1'b1, 32'h120);
    cycle(4'b0010, "lock_eop");
    in_valid[1] = 1'b0;
    cycle(4'b0100, "after_unlock");
    clear_all();

    // Non-writing and r0 packets are consumed without a write
    set_unit(0, 4'b1111, 6'd4, 1'b0, 1'b1, 1'b1, 32'h300);
    cycle(4'b0001, "wb0");
    set_unit(0, 4'b1111, 6'd0, 1'b1, 1'b1, 1'b1, 32'h310);
    cycle(4'b0001, "rd0");
    clear_all();
    cycle(4'b0000, "drop_idle");

    // Reset while locked on unit 3
    set_unit(3, 4'b1111, 6'd3, 1'b1, 1'b1, 1'b0, 32'h400);
    cycle(4'b1000, "lock3_sop");
    set_unit(0, 4'b1111, 6'd1, 1'b1, 1'b1, 1'b1, 32'h410);
    set_unit(3, 4'b1111, 6'd3, 1'b1, 1'b0, 1'b0, 32'h420);
    cycle(4'b1000, "lock3_mid");
    do_reset();
    set_unit(3, 4'b1111, 6'd3, 1'b1, 1'b1, 1'b1, 32'h430);
    cycle(4'b0001, "post_reset_u0");
    cycle(4'b1000, "post_reset_u3");
    clear_all();

`ifdef VX_WB_ARB_PERF_EN
    do_reset();
    for (int u = 0; u < 3; u++) set_unit(u, 4'b1111, 6'(20 + u), 1'b1, 1'b1, 1'b1, 32'(u*64));
    cycle(4'b0001, "perf_a");
    cycle(4'b0010, "perf_b");
    cycle(4'b0100, "perf_c");
    cycle(4'b0001, "perf_d");
    checks++;
    if (perf_stalls !== PCB'(4)) begin
      failures++;
      $display("FAIL perf_contended got %0d want 4", perf_stalls);
    end
    clear_all();
    set_unit(1, 4'b1111, 6'd30, 1'b1, 1'b1, 1'b1, 32'h500);
    cycle(4'b0010, "perf_solo");
    cycle(4'b0010, "perf_solo");
    cycle(4'b0010, "perf_solo");
    checks++;
    if (perf_stalls !== PCB'(4)) begin
      failures++;
      $display("FAIL perf_solo got %0d want 4", perf_stalls);
    end
    clear_all();
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_writes got %0d outstanding want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
